ram_sync_bw: RTL and testbench

//   Parametrised single-port synchronous RAM, successor to the 8-bit tristate RAM.

---
 rtl/ram_sync_bw_if.sv | 27 ++
 rtl/ram_sync_bw.sv | 166 ++++++++++++++++
 tb/tb_ram_sync_bw.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_bw_if.sv
// Request/response bus of the byte-write synchronous RAM.
// The master drives requests; the slave (the RAM) returns ready, init status and read results.
interface ram_sync_bw_if #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      cs;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      ready;
    logic                      init_done;
    logic                      rvalid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rd_perr;

    modport master (
        output cs, we, be, addr, wdata,
        input  ready, init_done, rvalid, rdata, rd_perr
    );

    modport slave (
        input  cs, we, be, addr, wdata,
        output ready, init_done, rvalid, rdata, rd_perr
    );
endinterface

// File: rtl/ram_sync_bw.sv
// Single-port synchronous RAM with byte enables, zero-fill after reset and a pipelined read.
// Optional per-byte even parity is enabled with the RAM_PARITY_EN macro.
module ram_sync_bw #(
    parameter int unsigned ADDR_WIDTH   = 13,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LENGTH       = 1 << ADDR_WIDTH,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_sync_bw_if.slave    bus
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned AW1   = ADDR_WIDTH + 1;
    localparam int unsigned LAT   = READ_LATENCY;
    localparam logic [AW1-1:0] LEN_A = AW1'(LENGTH);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   fill_ptr_q;
    logic               ready_q;
    logic               init_done_q;

    logic [DATA_WIDTH-1:0] mem [0:LENGTH-1];

    logic               in_range_c;
    logic [IDX_W-1:0]   idx_c;
    logic               wr_c;
    logic               rd_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    // Zero-fill one word per cycle, then serve requests until the next reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            fill_ptr_q  <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (fill_ptr_q == IDX_W'(LENGTH - 1)) begin
                        state_q     <= ST_IDLE;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
                    end else begin
                        fill_ptr_q  <= fill_ptr_q + IDX_W'(1);
                    end
                end
                ST_IDLE: begin
                    ready_q     <= 1'b1;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_INIT;
                    fill_ptr_q  <= '0;
                    ready_q     <= 1'b0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        in_range_c = ({1'b0, bus.addr} < LEN_A);
        idx_c      = bus.addr[IDX_W-1:0];
        wr_c       = bus.cs && ready_q && bus.we && in_range_c;
        rd_c       = bus.cs && ready_q && !bus.we;
        rd_data_c  = in_range_c ? mem[idx_c] : '0;
    end

    // Storage array: fill has priority, no reset so it maps onto a RAM macro
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[fill_ptr_q] <= '0;
        end else if (wr_c) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.be[b]) begin
                    mem[idx_c][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    logic [LAT-1:0]        vld_q;
    logic [DATA_WIDTH-1:0] dat_q [LAT];

    // Read pipeline; a stage only loads on a valid result so rdata holds between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_c;
            if (rd_c) begin
                dat_q[0] <= rd_data_c;
            end
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.init_done = init_done_q;
    assign bus.rvalid    = vld_q[LAT-1];
    assign bus.rdata     = dat_q[LAT-1];

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [0:LENGTH-1];
    logic [NB-1:0] wr_par_c;
    logic [NB-1:0] rd_par_c;
    logic          rd_perr_c;
    logic [LAT-1:0] perr_q;

    always_comb begin
        wr_par_c = '0;
        rd_par_c = '0;
        for (int b = 0; b < NB; b++) begin
            wr_par_c[b] = ^bus.wdata[8*b +: 8];
            rd_par_c[b] = ^rd_data_c[8*b +: 8];
        end
        rd_perr_c = in_range_c && (|(rd_par_c ^ par_mem[idx_c]));
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            par_mem[fill_ptr_q] <= '0;
        end else if (wr_c) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.be[b]) begin
                    par_mem[idx_c][b] <= wr_par_c[b];
                end
            end
        end
    end

    // Error flag travels with its result and is zero on every non-result cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= '0;
        end else begin
            perr_q[0] <= rd_c && rd_perr_c;
            for (int k = 1; k < LAT; k++) begin
                perr_q[k] <= perr_q[k-1];
            end
        end
    end

    assign bus.rd_perr = perr_q[LAT-1];
`else
    assign bus.rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sync_bw.sv
// Randomized self-checking bench for ram_sync_bw against an array/queue reference model.
module tb_ram_sync_bw;

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned LEN = 16;
    localparam int unsigned LAT = 2;
    localparam int unsigned NB  = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_sync_bw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_sync_bw #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .LENGTH       (LEN),
        .READ_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          p;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [LEN];
    logic [NB-1:0] bad   [LEN];
    int            edge_cnt;
    logic [DW-1:0] last_rdata;
    int            n_cmp;
    int            n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: update the model with whatever the edge accepts, then check outputs
    task automatic step();
        exp_t e;
        logic acc;
        int   a;
        acc = bus.cs && (edge_cnt >= LEN);
        a   = int'(bus.addr);
        if (acc && bus.we && a < LEN) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.be[b]) begin
                    model[a][8*b +: 8] = bus.wdata[8*b +: 8];
                    bad[a][b] = 1'b0;
                end
            end
        end else if (acc && !bus.we) begin
            e.d   = (a < LEN) ? model[a] : '0;
            e.p   = (a < LEN) ? (|bad[a]) : 1'b0;
            e.due = edge_cnt + LAT;
            exp_q.push_back(e);
        end
        @(posedge clk);
        edge_cnt++;
        #1;
        chk("ready", 64'(bus.ready), 64'(edge_cnt >= LEN));
        chk("init_done", 64'(bus.init_done), 64'(edge_cnt >= LEN));
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            e = exp_q.pop_front();
            chk("rvalid", 64'(bus.rvalid), 64'(1));
            chk("rdata", 64'(bus.rdata), 64'(e.d));
            chk("rd_perr", 64'(bus.rd_perr), 64'(e.p));
            last_rdata = e.d;
        end else begin
            chk("rvalid_idle", 64'(bus.rvalid), 64'(0));
            chk("rdata_hold", 64'(bus.rdata), 64'(last_rdata));
            chk("rd_perr_idle", 64'(bus.rd_perr), 64'(0));
        end
    endtask

    task automatic drive(input logic cs, input logic we, input logic [NB-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.cs    = cs;
        bus.we    = we;
        bus.be    = be;
        bus.addr  = a;
        bus.wdata = wd;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, '0, '0, '0);
        end
    endtask

    task automatic do_reset(input int hold);
        bus.cs = 1'b0;
        rst_n  = 1'b0;
        #2;
        chk("rst_ready", 64'(bus.ready), 64'(0));
        chk("rst_init_done", 64'(bus.init_done), 64'(0));
        chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
        chk("rst_rdata", 64'(bus.rdata), 64'(0));
        chk("rst_rd_perr", 64'(bus.rd_perr), 64'(0));
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        edge_cnt   = 0;
        last_rdata = '0;
        for (int i = 0; i < LEN; i++) begin
            model[i] = '0;
            bad[i]   = '0;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        bus.cs    = 1'b0;
        bus.we    = 1'b0;
        bus.be    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        do_reset(2);

        // Requests during the fill are ignored
        for (int i = 0; i < LEN; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), '1, AW'($urandom), DW'($urandom));
        end
        for (int i = 0; i < LEN; i++) begin
            drive(1'b1, 1'b0, '0, AW'(i), '0);
        end
        idle(LAT);

        drive(1'b1, 1'b1, 4'b1111, AW'(5), 32'hDEADBEEF);
        drive(1'b1, 1'b0, '0, AW'(5), '0);
        idle(LAT);
        drive(1'b1, 1'b1, 4'b0101, AW'(5), 32'h11223344);
        drive(1'b1, 1'b0, '0, AW'(5), '0);
        idle(LAT);
        chk("merge_value", 64'(last_rdata), 64'(32'hDE22BE44));

        drive(1'b1, 1'b1, 4'b1111, AW'(1), 32'hA1A1A1A1);
        drive(1'b1, 1'b1, 4'b1111, AW'(2), 32'hB2B2B2B2);
        drive(1'b1, 1'b1, 4'b1111, AW'(3), 32'hC3C3C3C3);
        drive(1'b1, 1'b0, '0, AW'(1), '0);
        drive(1'b1, 1'b0, '0, AW'(2), '0);
        drive(1'b1, 1'b0, '0, AW'(3), '0);
        idle(LAT + 1);

        // Out-of-range write must not alias onto a low word
        drive(1'b1, 1'b1, 4'b1111, AW'(20), 32'h55AA55AA);
        drive(1'b1, 1'b0, '0, AW'(20), '0);
        drive(1'b1, 1'b0, '0, AW'(4), '0);
        drive(1'b1, 1'b1, 4'b0000, AW'(6), 32'hFFFFFFFF);
        drive(1'b1, 1'b0, '0, AW'(6), '0);
        idle(LAT);

`ifdef RAM_PARITY_EN
        drive(1'b1, 1'b1, 4'b1111, AW'(7), 32'h01020304);
        dut.par_mem[7][1] = ~dut.par_mem[7][1];
        bad[7][1] = 1'b1;
        drive(1'b1, 1'b0, '0, AW'(7), '0);
        drive(1'b1, 1'b0, '0, AW'(6), '0);
        drive(1'b1, 1'b0, '0, AW'(8), '0);
        idle(LAT);
`endif

        // Reset with reads in flight: no stale rvalid afterwards
        drive(1'b1, 1'b0, '0, AW'(5), '0);
        bus.cs = 1'b1;
        do_reset(1);
        idle(LEN + 2);
        drive(1'b1, 1'b0, '0, AW'(5), '0);
        idle(LAT);

        // Reset in the middle of the fill restarts it
        do_reset(1);
        idle(7);
        do_reset(1);
        for (int i = 0; i < LEN + 4; i++) begin
            drive(1'b1, 1'b0, '0, AW'(i % LEN), '0);
        end
        idle(LAT);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset(int'($urandom_range(1, 3)));
            end
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  NB'($urandom), AW'($urandom), DW'($urandom));
        end
        idle(LAT + 1);
        chk("drain", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
